// File: rtl/dm_store_port.sv
// MEM-stage store port: byte-lane formation, DEPTH-entry FIFO write buffer and req/ack drain.
// Optional feature macro MISALIGN_EXC_EN adds the ades_o misaligned-store exception output.
module dm_store_port #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          memwrite_i,
   input  logic [1:0]    dmictr_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   input  logic          load_i,
   output logic          stall_o,
   output logic          ld_hit_o,
   output logic          mem_req_o,
   input  logic          mem_ack_i,
   output logic [AW-3:0] mem_addr_o,
   output logic [3:0]    mem_be_o,
   output logic [31:0]   mem_wdata_o,
`ifdef MISALIGN_EXC_EN
   output logic          ades_o,
`endif
   output logic          empty_o
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t        r_state;
   logic [AW-3:0] r_addr [DEPTH];
   logic [3:0]    r_be   [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [PW:0]   r_cnt;

   logic [PW:0]   w_cnt_next;
   logic          w_push, w_pop, w_full, w_ades, w_hit;
   logic [3:0]    w_be;
   logic [31:0]   w_data;

   // Misaligned word/half stores fall onto the aligned lanes because the low
   // address bits they would need are simply not consulted.
   always_comb begin
      w_be   = 4'b0000;
      w_data = 32'h0;
      case (dmictr_i)
         2'b01: begin
            w_be   = 4'b1111;
            w_data = wdata_i;
         end
         2'b10: begin
            if (addr_i[1]) begin
               w_be   = 4'b1100;
               w_data = {wdata_i[15:0], 16'h0};
            end else begin
               w_be   = 4'b0011;
               w_data = {16'h0, wdata_i[15:0]};
            end
         end
         2'b11: begin
            w_be   = 4'b0001 << addr_i[1:0];
            w_data = {4{wdata_i[7:0]}};
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_EXC_EN
   assign w_ades = memwrite_i & (((dmictr_i == 2'b01) & (addr_i[1:0] != 2'b00)) |
                                 ((dmictr_i == 2'b10) & addr_i[0]));
   assign ades_o = w_ades;
`else
   assign w_ades = 1'b0;
`endif

   // An entry is valid when its distance from the read pointer is below count.
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] off;
         off = PW'(i) - r_rp;
         if (({1'b0, off} < r_cnt) && (r_addr[i] == addr_i[AW-1:2]))
            w_hit = 1'b1;
      end
   end

   assign mem_req_o   = (r_state == S_REQ);
   assign w_pop       = mem_req_o & mem_ack_i;
   assign w_full      = (r_cnt == (PW+1)'(DEPTH));
   assign ld_hit_o    = load_i & w_hit;
   assign stall_o     = ld_hit_o | (memwrite_i & ~w_ades & w_full & ~w_pop);
   assign w_push      = memwrite_i & (dmictr_i != 2'b00) & ~w_ades & ~stall_o;
   assign w_cnt_next  = r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
   assign empty_o     = (r_cnt == '0);

   assign mem_addr_o  = mem_req_o ? r_addr[r_rp] : '0;
   assign mem_be_o    = mem_req_o ? r_be[r_rp]   : '0;
   assign mem_wdata_o = mem_req_o ? r_data[r_rp] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_state <= S_IDLE;
      end else begin
         if (w_push) r_wp <= r_wp + PW'(1);
         if (w_pop)  r_rp <= r_rp + PW'(1);
         r_cnt <= w_cnt_next;
         case (r_state)
            S_IDLE:  if (r_cnt != '0) r_state <= S_REQ;
            S_REQ:   if (w_pop && (w_cnt_next == '0)) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: buffer storage has no reset; entries are only observed through
   // pointers and count, which are reset, so skipping it keeps it as plain RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wp] <= addr_i[AW-1:2];
         r_be[r_wp]   <= w_be;
         r_data[r_wp] <= w_data;
      end
   end

endmodule

// File: tb/tb_dm_store_port.sv
// Self-checking bench for dm_store_port: directed steps plus random traffic against a queue model.
module tb_dm_store_port;

   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          memwrite = 1'b0;
   logic [1:0]    dmictr = 2'b00;
   logic [AW-1:0] addr = '0;
   logic [31:0]   wdata = '0;
   logic          load = 1'b0;
   logic          ack = 1'b0;
   logic          stall, ld_hit, mem_req, empty;
   logic [AW-3:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
`ifdef MISALIGN_EXC_EN
   logic          ades;
`endif

   dm_store_port #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .memwrite_i(memwrite), .dmictr_i(dmictr),
      .addr_i(addr), .wdata_i(wdata), .load_i(load), .stall_o(stall),
      .ld_hit_o(ld_hit), .mem_req_o(mem_req), .mem_ack_i(ack),
      .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
`ifdef MISALIGN_EXC_EN
      .ades_o(ades),
`endif
      .empty_o(empty)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [29:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } ent_t;

   ent_t q[$];
   logic m_req = 1'b0;
   int   n_pass = 0, n_total = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t form(input logic [1:0] dm, input logic [31:0] ad, input logic [31:0] wd);
      ent_t e;
      int   sh;
      e.a  = ad[31:2];
      e.be = 4'h0;
      e.d  = 32'h0;
      if (dm == 2'd1) begin
         e.be = 4'hF;
         e.d  = wd;
      end else if (dm == 2'd2) begin
         sh   = ad[1] ? 16 : 0;
         e.be = 4'(4'h3 << (sh / 8));
         e.d  = (wd & 32'hFFFF) << sh;
      end else if (dm == 2'd3) begin
         e.be = 4'(1 << ad[1:0]);
         e.d  = (wd & 32'hFF) * 32'h01010101;
      end
      return e;
   endfunction

   function automatic logic m_ades();
`ifdef MISALIGN_EXC_EN
      return memwrite && (((dmictr == 2'd1) && (addr[1:0] != 2'd0)) ||
                          ((dmictr == 2'd2) && addr[0]));
`else
      return 1'b0;
`endif
   endfunction

   // One clock of the model: check current outputs, then advance on the edge.
   task automatic cycle();
      logic e_hit, e_stall, e_push, e_pop, ad, nreq;
      int   s, s_after;
      ent_t e;
      #1;
      e_hit = 1'b0;
      if (load) foreach (q[i]) if (q[i].a == addr[31:2]) e_hit = 1'b1;
      ad      = m_ades();
      e_pop   = m_req && ack;
      e_stall = e_hit || (memwrite && !ad && (q.size() == DEPTH) && !e_pop);
      e_push  = memwrite && (dmictr != 2'd0) && !ad && !e_stall;
      check("stall", stall, e_stall);
      check("ld_hit", ld_hit, e_hit);
      check("req", mem_req, m_req);
      check("empty", empty, q.size() == 0);
`ifdef MISALIGN_EXC_EN
      check("ades", ades, ad);
`endif
      if (m_req) begin
         check("head_addr", mem_addr, q[0].a);
         check("head_be", mem_be, q[0].be);
         check("head_data", mem_wdata, q[0].d);
      end else begin
         check("idle_bus", {mem_addr, mem_be, mem_wdata}, 64'h0);
      end
      e       = form(dmictr, addr, wdata);
      s       = q.size();
      s_after = s - int'(e_pop) + int'(e_push);
      nreq    = m_req ? !(e_pop && (s_after == 0)) : (s != 0);
      @(posedge clk);
      if (e_pop)  void'(q.pop_front());
      if (e_push) q.push_back(e);
      m_req = nreq;
      #1;
   endtask

   task automatic store(input logic [1:0] dm, input logic [31:0] ad, input logic [31:0] wd);
      memwrite = 1'b1;
      dmictr   = dm;
      addr     = ad;
      wdata    = wd;
   endtask

   initial begin
      #12;
      check("rst_stall", stall, 1'b0);
      check("rst_req", mem_req, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_bus", {ld_hit, mem_addr, mem_be, mem_wdata}, 64'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Byte store, ack tied high.
      ack = 1'b1;
      store(2'd3, 32'h13, 32'hA5);
      cycle();
      memwrite = 1'b0;
      cycle();
      #1;
      check("sb_req", mem_req, 1'b1);
      check("sb_addr", mem_addr, 30'h4);
      check("sb_be", mem_be, 4'b1000);
      check("sb_data", mem_wdata, 32'hA5A5A5A5);
      cycle();
      #1;
      check("sb_empty", empty, 1'b1);

      // Upper half store.
      store(2'd2, 32'h102, 32'h0000BEEF);
      cycle();
      memwrite = 1'b0;
      cycle();
      #1;
      check("sh_be", mem_be, 4'b1100);
      check("sh_data", mem_wdata, 32'hBEEF0000);
      check("sh_addr", mem_addr, 30'h40);
      cycle();

      // dmictr=0 with memwrite is ignored.
      store(2'd0, 32'h40, 32'h1);
      cycle();
      memwrite = 1'b0;
      #1;
      check("none_empty", empty, 1'b1);

      // Fill, stall on fifth, then simultaneous pop and push.
      ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         store(2'd1, 32'h300 + 32'(4 * i), $urandom);
         if (i == 4) begin
            #1;
            check("full_stall", stall, 1'b1);
         end
         cycle();
      end
      ack = 1'b1;
      #1;
      check("popush_nostall", stall, 1'b0);
      cycle();
      ack = 1'b0;
      store(2'd1, 32'h320, 32'h5);
      #1;
      check("still_full", stall, 1'b1);
      memwrite = 1'b0;
      ack = 1'b1;
      for (int k = 0; k < 20 && !empty; k++) cycle();
      check("drain_done", empty, 1'b1);
      cycle();

      // Load hazard against a pending store.
      ack = 1'b0;
      store(2'd1, 32'h200, 32'h11223344);
      cycle();
      memwrite = 1'b0;
      load = 1'b1;
      addr = 32'h202;
      #1;
      check("hit", ld_hit, 1'b1);
      check("hit_stall", stall, 1'b1);
      cycle();
      cycle();
      ack = 1'b1;
      cycle();
      ack = 1'b0;
      #1;
      check("hit_clear", ld_hit, 1'b0);
      check("hit_nostall", stall, 1'b0);
      load = 1'b0;
      cycle();

      // Asynchronous reset mid-drain.
      for (int i = 0; i < 3; i++) begin
         store(2'd1, 32'h500 + 32'(4 * i), $urandom);
         cycle();
      end
      memwrite = 1'b0;
      cycle();
      check("pre_rst_req", mem_req, 1'b1);
      reset = 1'b0;
      #1;
      check("arst_req", mem_req, 1'b0);
      check("arst_empty", empty, 1'b1);
      check("arst_stall", stall, 1'b0);
      q.delete();
      m_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      ack = 1'b1;
      repeat (4) cycle();

      // Misaligned word store.
      store(2'd1, 32'h201, 32'hCAFEF00D);
`ifdef MISALIGN_EXC_EN
      #1;
      check("ades_on", ades, 1'b1);
      cycle();
      memwrite = 1'b0;
      #1;
      check("ades_empty", empty, 1'b1);
      cycle();
`else
      cycle();
      memwrite = 1'b0;
      cycle();
      #1;
      check("mis_addr", mem_addr, 30'h80);
      check("mis_be", mem_be, 4'b1111);
      cycle();
`endif

      // Random traffic over a small address window to provoke hits and fullness.
      for (int n = 0; n < 300; n++) begin
         memwrite = 1'($urandom_range(0, 1));
         dmictr   = 2'($urandom_range(0, 3));
         addr     = 32'h400 + 32'($urandom_range(0, 31));
         wdata    = $urandom;
         load     = ($urandom_range(0, 3) == 0);
         ack      = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dm_store_port.md
Name: dm_store_port

Overview:
- Memory-side responder for the MEM-stage store-control interface (memwrite, dmictr, address, store data).
- Converts each store into a word address, 4-bit byte-enable and lane-aligned write data.
- Holds stores in a small FIFO write buffer and drains them over a req/ack port to FPGA block RAM or the peripheral bridge.
- Stalls the pipeline when full and flags loads that hit a pending store.

Parameters:
- DEPTH, 4, write-buffer entries; power of 2, minimum 2.
- AW, 32, byte-address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- memwrite_i  in  1  store request from the MEM stage.
- dmictr_i  in  2  store size: 2'b01 word, 2'b10 half, 2'b11 byte, 2'b00 none.
- addr_i  in  AW  byte address of the store or load.
- wdata_i  in  32  store data; byte/half data in the low bits.
- load_i  in  1  MEM-stage load present (address on addr_i).
- stall_o  out  1  pipeline must hold MEM.
- ld_hit_o  out  1  load word address matches a buffered store.
- mem_req_o  out  1  drain request.
- mem_ack_i  in  1  memory accepted the current request.
- mem_addr_o  out  AW-2  word address.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-aligned data.
- empty_o  out  1  buffer empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0 except empty_o=1.
  - Pointers and count clear; buffer contents are don't-care.
- Enqueue:
  - Occurs when memwrite_i=1, dmictr_i!=0 and stall_o=0, on the rising clk edge.
  - memwrite_i=1 with dmictr_i=0 is ignored.
- Lane formation:
  - word: be=4'b1111, data=wdata_i.
  - half: addr[1]=0 gives be=4'b0011, data={16'b0, wdata[15:0]}; addr[1]=1 gives be=4'b1100, data={wdata[15:0], 16'b0}.
  - byte: be=4'b0001<<addr[1:0]; data=wdata[7:0] replicated into all 4 lanes.
  - Entry stores addr[AW-1:2], be and data.
- Drain state machine, 2 states:
  - IDLE: mem_req_o=0. Moves to REQ on the cycle after count becomes nonzero; first request appears 1 cycle after enqueue into an empty buffer.
  - REQ: mem_req_o=1, head entry driven on mem_addr_o/mem_be_o/mem_wdata_o, held stable until mem_ack_i=1.
  - On ack the head pops. Stay in REQ if count after pop is nonzero (back-to-back drain, one entry per acked cycle); otherwise go to IDLE.
  - mem_ack_i while mem_req_o=0 is ignored.
- Full behaviour:
  - stall_o = memwrite_i & (count==DEPTH) & ~(mem_req_o & mem_ack_i). Combinational.
  - Simultaneous pop and push when full: push is accepted and count is unchanged.
- Load hazard:
  - ld_hit_o = load_i & (some valid entry's word address == addr_i[AW-1:2]). Combinational over all valid entries.
  - stall_o also asserts when ld_hit_o=1, so loads wait for the matching store to drain.
  - An entry popping in the same cycle still counts as a hit.
- Pointers:
  - log2(DEPTH) bits, wrapping modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- empty_o = (count==0), registered via count.
- Reset mid-drain: buffer is discarded and mem_req_o drops immediately (asynchronous).

Optional Feature:
- Macro: MISALIGN_EXC_EN.
- Defined:
  - Adds output ades_o (1 bit, combinational).
  - ades_o asserts for a word store with addr[1:0]!=0, or a half store with addr[0]=1, when memwrite_i=1.
  - Such a store is not enqueued and does not raise stall_o.
- Undefined:
  - No ades_o port.
  - Misaligned stores have their low address bits forced to the aligned position (word: addr[1:0] treated as 0; half: addr[0] treated as 0) and are enqueued normally.

Test Plan:
- Reset, then sb to addr 0x00000013 with wdata 0x000000A5, mem_ack_i tied 1:
  - mem_req_o rises 1 cycle later with mem_addr_o=0x4, be=4'b1000, data=0xA5A5A5A5.
  - Request is acked in that cycle; empty_o=1 next cycle.
- sh to 0x102 with wdata 0x0000BEEF:
  - be=4'b1100, data=0xBEEF0000, mem_addr_o=0x40.
- DEPTH=4, mem_ack_i=0, five consecutive sw:
  - First four enqueue; stall_o=1 on the fifth.
  - Raising mem_ack_i for one cycle accepts the fifth store in that same cycle; count stays 4.
- sw 0x11223344 to 0x200 pending with ack held low, then load_i=1 at 0x202:
  - ld_hit_o=1, stall_o=1.
  - After ack, ld_hit_o=0.
- Assert reset=0 while mem_req_o=1 with 3 entries pending:
  - mem_req_o=0 and empty_o=1 with no clock edge.
  - After release, no stale requests.
- With MISALIGN_EXC_EN, sw to 0x201:
  - ades_o=1, no enqueue, empty_o stays 1.
- Without MISALIGN_EXC_EN, same store:
  - enqueued with mem_addr_o=0x80, be=4'b1111.
